ins_11: RTL and testbench

- Single-cycle MIPS-style datapath: register file, ALU, instruction decoder and a small data memory.
- Executes one 32-bit instruction per clock, presented on `codigo`.
- Exports the ALU zero flag `cero`.
- Used as the execution core of the processor; instruction fetch is external.

---
 rtl/ins_11.sv | 134 +++++++++++++
 tb/tb_ins_11.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ins_11.sv
// ins_11: single-cycle MIPS-style execution core (regfile, ALU, decoder, data memory); optional debug taps under INS11_REGDUMP_EN.
// Latency: reads and cero are combinational from codigo; register/memory writes commit on the next rising clk edge.
// Backpressure: none, one instruction is consumed every cycle and rst suppresses writes and forces cero low.
module ins_11 #(
  parameter int MEM_DEPTH = 32,
  parameter int REG_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] codigo,
  output logic        cero
`ifdef INS11_REGDUMP_EN
  ,
  output logic [31:0] dbg_resultado,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_reg
`endif
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001100;
  localparam logic [5:0] OP_ANDI  = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100110;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b000001;
  localparam logic [5:0] FN_SUB = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b000011;
  localparam logic [5:0] FN_OR  = 6'b000100;

  logic [31:0] regs [REG_COUNT];
  logic [31:0] mem  [MEM_DEPTH];

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic        legal;
  logic        reg_we;
  logic        mem_we;
  logic        use_mem;
  logic [4:0]  wr_idx;
  logic [31:0] alu_res;
  logic [31:0] wb_val;
  logic [AW-1:0] addr;
  logic        unused_shamt;

  assign op     = codigo[31:26];
  assign rs     = codigo[25:21];
  assign rt     = codigo[20:16];
  assign rd     = codigo[15:11];
  assign funct  = codigo[5:0];
  assign imm    = codigo[15:0];
  assign imm_s  = {{16{imm[15]}}, imm};
  assign imm_z  = {16'b0, imm};
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];
  assign unused_shamt = ^codigo[10:6];

  // Decode the instruction and compute the ALU result and write controls.
  always_comb begin
    legal   = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    use_mem = 1'b0;
    wr_idx  = rt;
    alu_res = 32'd0;
    case (op)
      OP_RTYPE: begin
        wr_idx = rd;
        case (funct)
          FN_ADD: begin legal = 1'b1; alu_res = rs_val + rt_val; end
          FN_SUB: begin legal = 1'b1; alu_res = rs_val - rt_val; end
          FN_AND: begin legal = 1'b1; alu_res = rs_val & rt_val; end
          FN_OR:  begin legal = 1'b1; alu_res = rs_val | rt_val; end
          default: legal = 1'b0;
        endcase
        reg_we = legal;
      end
      OP_ADDI: begin legal = 1'b1; reg_we = 1'b1; alu_res = rs_val + imm_s; end
      OP_ORI:  begin legal = 1'b1; reg_we = 1'b1; alu_res = rs_val | imm_z; end
      OP_ANDI: begin legal = 1'b1; reg_we = 1'b1; alu_res = rs_val & imm_z; end
      OP_LW:   begin legal = 1'b1; reg_we = 1'b1; use_mem = 1'b1; alu_res = rs_val + imm_s; end
      OP_SW:   begin legal = 1'b1; mem_we = 1'b1; alu_res = rs_val + imm_s; end
      default: legal = 1'b0;
    endcase
  end

  // Address wraps: only the low bits of the sum select the word.
  assign addr   = alu_res[AW-1:0];
  assign wb_val = use_mem ? mem[addr] : alu_res;
  assign cero   = !rst && legal && (alu_res == 32'd0);

`ifdef INS11_REGDUMP_EN
  assign dbg_resultado = wb_val;
  assign dbg_reg       = regs[dbg_sel];
`endif

  // Register file: reset to the boot pattern, otherwise commit the writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 32'd0;
      regs[0] <= 32'd3;
      regs[1] <= 32'd1;
      regs[2] <= 32'd2;
      regs[3] <= 32'd4;
    end else if (reg_we) begin
      regs[wr_idx] <= wb_val;
    end
  end

  // Data memory: reset to the boot pattern, otherwise commit stores.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'd0;
      mem[3] <= 32'd15;
      mem[4] <= 32'd4;
      mem[5] <= 32'd5;
    end else if (mem_we) begin
      mem[addr] <= rt_val;
    end
  end

endmodule

// File: tb/tb_ins_11.sv
// tb_ins_11: directed checks of ins_11 observing state through the cero flag.
// Latency: each instruction is held one clock; cero is sampled 1 time unit after codigo changes.
// Backpressure: none; the bench drives one instruction per cycle.
module tb_ins_11;

  logic        clk;
  logic        rst;
  logic [31:0] codigo;
  logic        cero;

  int checks;
  int failures;

  localparam int ADDI = 6'b001000;
  localparam int ORI  = 6'b001100;
  localparam int ANDI = 6'b001101;
  localparam int LW   = 6'b100110;
  localparam int SW   = 6'b101011;
  localparam int SCR  = 10;  // scratch register used by probes

  ins_11 dut (
    .clk    (clk),
    .rst    (rst),
    .codigo (codigo),
    .cero   (cero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    logic [31:0] w;
    w = {6'b0, rs[4:0], rt[4:0], rd[4:0], 5'b0, fn[5:0]};
    return w;
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    logic [31:0] w;
    w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    return w;
  endfunction

  // Apply one instruction for one cycle, checking cero before the commit edge.
  task automatic exec(input string tag, input logic [31:0] instr, input logic exp_cero);
    codigo = instr;
    #1;
    check(tag, 32'(cero), 32'(exp_cero));
    @(posedge clk);
    #1;
  endtask

  // Verify register r holds v: addi scratch, r, -v must produce zero.
  task automatic probe(input string tag, input int r, input int v);
    exec(tag, itype(ADDI, r, SCR, -v), 1'b1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    codigo   = rtype(2, 3, 25, 3);  // 2&4 == 0, yet cero must stay low in reset
    #1;
    check("reset_cero", 32'(cero), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset contents
    probe("rst_r0", 0, 3);
    probe("rst_r1", 1, 1);
    probe("rst_r2", 2, 2);
    probe("rst_r3", 3, 4);
    probe("rst_r5", 5, 0);
    exec("probe_neg", itype(ADDI, 1, SCR, -2), 1'b0);

    // R-type
    exec("add_r31_cero", rtype(1, 2, 31, 1), 1'b0);
    exec("sub_r28_cero", rtype(2, 1, 28, 2), 1'b0);
    exec("and_r25_cero", rtype(1, 2, 25, 3), 1'b1);
    exec("or_r22_cero",  rtype(1, 2, 22, 4), 1'b0);
    probe("add_r31", 31, 3);
    probe("sub_r28", 28, 1);
    probe("and_r25", 25, 0);
    probe("or_r22",  22, 3);
    exec("add_r30_cero", rtype(0, 1, 30, 1), 1'b0);
    exec("sub_r27_cero", rtype(0, 1, 27, 2), 1'b0);
    exec("sub_r26_cero", rtype(1, 2, 26, 2), 1'b0);
    probe("r0_add", 30, 4);
    probe("r0_sub", 27, 2);
    probe("sub_neg", 26, -1);

    // Loads, wrap and sign-extended offset
    exec("lw_r19_cero", itype(LW, 0, 19, 0), 1'b0);
    exec("lw_r18_cero", itype(LW, 0, 18, 1), 1'b0);
    exec("lw_r17_cero", itype(LW, 0, 17, 2), 1'b0);
    probe("lw_r19", 19, 15);
    probe("lw_r18", 18, 4);
    probe("lw_r17", 17, 5);
    exec("lw_addr0_cero", itype(LW, 0, 20, -3), 1'b1);
    exec("lw_wrap_cero", itype(LW, 0, 21, 32), 1'b0);
    probe("lw_wrap", 21, 15);

    // Store / load round trips
    exec("sw_m6_cero", itype(SW, 0, 1, 3), 1'b0);
    exec("lw_m6_cero", itype(LW, 0, 11, 3), 1'b0);
    probe("sw_lw_m6", 11, 1);
    exec("sw_m8_cero", itype(SW, 0, 3, 5), 1'b0);
    exec("lw_m8_cero", itype(LW, 0, 13, 5), 1'b0);
    probe("sw_lw_m8", 13, 4);

    // Immediates
    exec("addi_r16_cero", itype(ADDI, 1, 16, 1), 1'b0);
    exec("addi_r14_cero", itype(ADDI, 1, 14, 3), 1'b0);
    exec("ori_r12_cero",  itype(ORI, 1, 12, 2), 1'b0);
    exec("andi_r9_cero",  itype(ANDI, 1, 9, 2), 1'b1);
    exec("andi_r8_cero",  itype(ANDI, 1, 8, 3), 1'b0);
    probe("addi_r16", 16, 2);
    probe("addi_r14", 14, 4);
    probe("ori_r12",  12, 3);
    probe("andi_r9",  9, 0);
    probe("andi_r8",  8, 1);
    exec("ori_zext_cero", itype(ORI, 5, 7, 32768), 1'b0);
    probe("ori_zext", 7, 32768);
    exec("addi_sext_cero", itype(ADDI, 1, 6, -1), 1'b1);

    // Illegal op and funct: no write, cero low
    exec("ill_op_cero", itype(63, 25, 31, 0), 1'b0);
    probe("ill_op_r31", 31, 3);
    exec("ill_fn_cero", rtype(25, 25, 31, 0), 1'b0);
    probe("ill_fn_r31", 31, 3);

    // Same-cycle read/write returns the old value
    exec("rw_same_a", itype(ADDI, 1, 1, 1), 1'b0);
    probe("rw_same_r1", 1, 2);
    exec("rw_same_b", itype(ADDI, 1, 1, -2), 1'b1);
    probe("rw_zero_r1", 1, 0);

    // Mid-sequence reset
    rst = 1'b1;
    exec("rst_mid_cero0", rtype(2, 3, 25, 3), 1'b0);
    exec("rst_mid_cero1", itype(ADDI, 0, 31, 9), 1'b0);
    rst = 1'b0;
    probe("rst_mid_r31", 31, 0);
    probe("rst_mid_r1", 1, 1);
    exec("rst_lw_m6_cero", itype(LW, 0, 11, 3), 1'b0);
    probe("rst_mid_m6", 11, 0);
    exec("rst_lw_m5_cero", itype(LW, 0, 11, 2), 1'b0);
    probe("rst_mid_m5", 11, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
